alu_sequencer: RTL

Multi-cycle control unit that sequences the 16-bit ALU into a working processor core. It fetches instructions over a shared memory port and decodes them into ALU `oper`/`func`/`cond` fields and operands. It owns the PC and PSR, drives the register file, and arbitrates the single memory port between instruction fetch and LOAD/STORE. One instruction completes per pass through the state machine; there is no overlap between instructions.

---
 rtl/alu_sequencer_if.sv | 11 +
 rtl/alu_sequencer.sv | 127 ++++++++++++
 2 files changed

// File: rtl/alu_sequencer_if.sv
// alu_sequencer_if: shared instruction/data memory port between sequencer and memory
interface alu_sequencer_if;
  logic mem_req;
  logic mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic mem_ready;
  modport master(output mem_req, mem_we, mem_addr, mem_wdata, input mem_rdata, mem_ready);
  modport slave(input mem_req, mem_we, mem_addr, mem_wdata, output mem_rdata, mem_ready);
endinterface

// File: rtl/alu_sequencer.sv
// alu_sequencer: multi-cycle fetch/decode/execute/mem/writeback control unit around an external 16-bit ALU
module alu_sequencer #(
  parameter logic [15:0] INIT_PC = 16'h0000
) (
  input  logic clk,
  input  logic rst_n,
  alu_sequencer_if.master mem,
  output logic [3:0] rf_raddr_a,
  output logic [3:0] rf_raddr_b,
  input  logic [15:0] rf_rdata_a,
  input  logic [15:0] rf_rdata_b,
  output logic rf_we,
  output logic [3:0] rf_waddr,
  output logic [15:0] rf_wdata,
  output logic [15:0] alu_dst,
  output logic [15:0] alu_src,
  output logic [3:0] alu_oper,
  output logic [3:0] alu_func,
  output logic [3:0] alu_cond,
  output logic [4:0] alu_cond_in,
  input  logic [15:0] alu_result,
  input  logic [4:0] alu_cond_out,
  input  logic alu_cond_wr,
  output logic instr_done,
  output logic [15:0] pc
);
  typedef enum logic [2:0] {INIT, FETCH, DECODE, EXECUTE, MEM, WRITEBACK} state_t;
  state_t state, state_nx;
  logic [15:0] ir, a, b, res;
  logic [4:0] psr;
  logic [3:0] op, fn;
  logic [15:0] sext8, zext8, sh4;
  logic special, is_load, is_store, is_jal, is_jcond, is_bcond, query;
  logic reg_ok, shf_ok, alu_op, wr_alu, imm_s, imm_z;
  assign op = ir[15:12];
  assign fn = ir[7:4];
  assign sext8 = {{8{ir[7]}}, ir[7:0]};
  assign zext8 = {8'h00, ir[7:0]};
  assign sh4 = {12'h000, ir[3:0]};
  assign special = op == 4'b0100;
  assign is_load = special && fn == 4'b0000;
  assign is_store = special && fn == 4'b0100;
  assign is_jal = special && fn == 4'b1000;
  assign is_jcond = special && fn == 4'b1100;
  assign is_bcond = op == 4'b1100;
  assign query = is_bcond || is_jcond;
  assign reg_ok = fn inside {4'h1, 4'h2, 4'h3, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'ha, 4'hb, 4'hd, 4'he};
  assign shf_ok = fn inside {4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h6};
  assign alu_op = !special && !is_bcond && (op != 4'h0 || reg_ok) && (op != 4'h8 || shf_ok);
  // CMP, TEST and CMPI only update flags
  assign wr_alu = alu_op && op != 4'hb && !(op == 4'h0 && (fn == 4'hb || fn == 4'h8));
  assign imm_s = op inside {4'h5, 4'h7, 4'h9, 4'ha, 4'hb, 4'hd, 4'he};
  assign imm_z = op inside {4'h1, 4'h2, 4'h3, 4'h6, 4'hf};
  assign alu_oper = query ? 4'b0100 : op;
  assign alu_func = query ? 4'b1101 : fn;
  assign alu_cond = ir[11:8];
  assign alu_cond_in = psr;
  assign alu_dst = a;
  // right-shift immediates are passed to the ALU as a negative shift count
  assign alu_src = imm_s ? sext8 : imm_z ? zext8 :
                   (op == 4'h8 && fn[3:2] == 2'b00) ? (fn[0] ? 16'h0000 - sh4 : sh4) : b;
  assign rf_raddr_a = ir[11:8];
  assign rf_raddr_b = ir[3:0];
  assign rf_waddr = ir[11:8];
  assign rf_wdata = is_jal ? pc : res;
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= INIT;
    else state <= state_nx;
  // next state and per-state control outputs
  always_comb begin
    state_nx = state;
    mem.mem_req = 1'b0;
    mem.mem_we = 1'b0;
    mem.mem_addr = pc;
    mem.mem_wdata = a;
    rf_we = 1'b0;
    instr_done = 1'b0;
    case (state)
      INIT: state_nx = FETCH;
      FETCH: begin
        mem.mem_req = 1'b1;
        state_nx = mem.mem_ready ? DECODE : FETCH;
      end
      DECODE: state_nx = EXECUTE;
      EXECUTE: state_nx = (is_load || is_store) ? MEM : WRITEBACK;
      MEM: begin
        mem.mem_req = 1'b1;
        mem.mem_we = is_store;
        mem.mem_addr = b;
        state_nx = mem.mem_ready ? WRITEBACK : MEM;
      end
      WRITEBACK: begin
        instr_done = 1'b1;
        rf_we = wr_alu || is_load || is_jal;
        state_nx = FETCH;
      end
      default: state_nx = INIT;
    endcase
  end
  // datapath registers; branch outcome is kept in res[0] from EXECUTE until WRITEBACK
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pc <= INIT_PC;
      ir <= '0;
      a <= '0;
      b <= '0;
      res <= '0;
      psr <= '0;
    end else begin
      if (state == FETCH && mem.mem_ready) begin
        ir <= mem.mem_rdata;
        pc <= pc + 16'd1;
      end
      if (state == DECODE) begin
        a <= rf_rdata_a;
        b <= rf_rdata_b;
      end
      if (state == EXECUTE) begin
        res <= alu_result;
        if (alu_cond_wr) psr <= alu_cond_out;
      end
      if (state == MEM && mem.mem_ready && is_load) res <= mem.mem_rdata;
      if (state == WRITEBACK && (is_jal || (is_jcond && res[0]))) pc <= b;
      if (state == WRITEBACK && is_bcond && res[0]) pc <= pc + sext8;
    end
endmodule
